// File: rtl/ram_result_reader.sv
// Result SRAM read-back: on start, fetches N_WORDS words from address 0 and streams each
// word MSB-first over a valid/ready serial port. Flags err when the SRAM misses its ry deadline.
module ram_result_reader #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned N_WORDS = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              cs_n,
  output logic              we_n,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] read_data,
  input  logic              ry,
  output logic              P_out,
  output logic              P_valid,
  output logic              P_first,
  input  logic              P_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned BitW = $clog2(DATA_W);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LastWord = ADDR_W'(N_WORDS - 1);
  localparam logic [BitW-1:0]   LastBit  = BitW'(DATA_W - 1);
  localparam logic [TmoW-1:0]   TmoLast  = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StShift,
    StDone
  } state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic [ADDR_W-1:0]   r_word;
  logic [ADDR_W-1:0]   w_word_d;
  logic [BitW-1:0]     r_bit;
  logic [BitW-1:0]     w_bit_d;
  logic [TmoW-1:0]     r_tmo;
  logic [TmoW-1:0]     w_tmo_d;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_d;

  logic [ADDR_W-1:0]   r_address;
  logic [ADDR_W-1:0]   w_address_d;
  logic                r_cs_n;
  logic                w_cs_n_d;
  logic                r_p_out;
  logic                w_p_out_d;
  logic                r_p_valid;
  logic                w_p_valid_d;
  logic                r_p_first;
  logic                w_p_first_d;
  logic                r_busy;
  logic                w_busy_d;
  logic                r_done;
  logic                w_done_d;
  logic                r_err;
  logic                w_err_d;

  logic                w_accept;
  logic                w_timeout;
  logic                w_start_ok;

  assign w_accept   = r_p_valid & P_ready;
  assign w_timeout  = (r_state == StWait) & ~ry & (r_tmo == TmoLast);
  assign w_start_ok = (r_state == StIdle) & start;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_word    <= '0;
      r_bit     <= '0;
      r_tmo     <= '0;
      r_shift   <= '0;
      r_address <= '0;
      r_cs_n    <= 1'b1;
      r_p_out   <= 1'b0;
      r_p_valid <= 1'b0;
      r_p_first <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_word    <= w_word_d;
      r_bit     <= w_bit_d;
      r_tmo     <= w_tmo_d;
      r_shift   <= w_shift_d;
      r_address <= w_address_d;
      r_cs_n    <= w_cs_n_d;
      r_p_out   <= w_p_out_d;
      r_p_valid <= w_p_valid_d;
      r_p_first <= w_p_first_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
      r_err     <= w_err_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    w_state_d = r_state;
    w_word_d  = r_word;
    w_bit_d   = r_bit;
    w_tmo_d   = r_tmo;
    w_shift_d = r_shift;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StReq;
          w_word_d  = '0;
        end
      end
      StReq: begin
        w_state_d = StWait;
        w_tmo_d   = '0;
      end
      StWait: begin
        if (ry) begin
          w_state_d = StShift;
          w_shift_d = read_data;
          w_bit_d   = '0;
        end else if (r_tmo == TmoLast) begin
          w_state_d = StDone;
        end else begin
          w_tmo_d = r_tmo + TmoW'(1);
        end
      end
      StShift: begin
        if (w_accept) begin
          w_shift_d = {r_shift[DATA_W-2:0], 1'b0};
          w_bit_d   = r_bit + BitW'(1);
          if (r_bit == LastBit) begin
            if (r_word == LastWord) begin
              w_state_d = StDone;
            end else begin
              w_word_d  = r_word + ADDR_W'(1);
              w_state_d = StReq;
            end
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so every port comes straight from a flop
  always_comb begin
    w_cs_n_d    = (w_state_d != StReq);
    w_address_d = (w_state_d == StReq) ? w_word_d : r_address;
    w_p_valid_d = (w_state_d == StShift);
    w_p_out_d   = w_p_valid_d & w_shift_d[DATA_W-1];
    w_p_first_d = w_p_valid_d & (w_bit_d == '0);
    w_busy_d    = (w_state_d == StReq) || (w_state_d == StWait) || (w_state_d == StShift);
    w_done_d    = (w_state_d == StDone);
    w_err_d     = r_err;
    if (w_start_ok) begin
      w_err_d = 1'b0;
    end else if (w_timeout) begin
      w_err_d = 1'b1;
    end
  end

  assign cs_n    = r_cs_n;
  assign we_n    = 1'b1;
  assign address = r_address;
  assign P_out   = r_p_out;
  assign P_valid = r_p_valid;
  assign P_first = r_p_first;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_ram_result_reader.sv
// Bench for ram_result_reader: SRAM responder, ready driver and a scoreboard monitor
// that checks addresses, serial bits, holds under backpressure and done/err outcomes.
module tb_ram_result_reader;

  localparam int ADDR_W  = 4;
  localparam int N_WORDS = 2;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  localparam logic [11:0] RstVec = {1'b1, 1'b1, 4'b0000, 6'b000000};

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              ry = 1'b0;
  logic              P_ready = 1'b1;
  logic [DATA_W-1:0] read_data = '0;
  logic              cs_n;
  logic              we_n;
  logic [ADDR_W-1:0] address;
  logic              P_out;
  logic              P_valid;
  logic              P_first;
  logic              busy;
  logic              done;
  logic              err;

  ram_result_reader #(
    .ADDR_W (ADDR_W),
    .N_WORDS(N_WORDS),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cs_n     (cs_n),
    .we_n     (we_n),
    .address  (address),
    .read_data(read_data),
    .ry       (ry),
    .P_out    (P_out),
    .P_valid  (P_valid),
    .P_first  (P_first),
    .P_ready  (P_ready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int sram_mode = 0;  // 0: answers with ry, 1: silent
  int fixed_dly = 2;  // 0 selects a random ry delay
  int rdy_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random

  logic [1:0]        q_bits[$];
  int                q_addr[$];
  logic              q_err[$];
  logic [DATA_W-1:0] mem[N_WORDS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    total++;
    bad++;
    $display("FAIL %s: got %s", name, what);
  endtask

  function automatic logic [11:0] outs();
    return {cs_n, we_n, address, P_out, P_valid, P_first, busy, done, err};
  endfunction

  // Reference model: the full expected dump for the current memory image
  task automatic push_dump(input bit timeout);
    if (timeout) begin
      q_addr.push_back(0);
      q_err.push_back(1'b1);
    end else begin
      for (int w = 0; w < N_WORDS; w++) begin
        q_addr.push_back(w);
        for (int b = DATA_W - 1; b >= 0; b--) begin
          q_bits.push_back({mem[w][b], b == DATA_W - 1});
        end
      end
      q_err.push_back(1'b0);
    end
  endtask

  // SRAM responder: ry some cycles after the cs_n strobe
  initial begin : sram
    int a;
    int d;
    forever begin
      @(negedge clk);
      if (rst && !cs_n && sram_mode == 0) begin
        a = int'(address) % N_WORDS;
        d = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 8));
        repeat (d) @(negedge clk);
        if (rst) begin
          ry = 1'b1;
          read_data = mem[a];
        end
        @(negedge clk);
        ry = 1'b0;
        read_data = $urandom;
      end
    end
  end

  initial begin : ready_drv
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: P_ready = 1'b1;
        1: begin
          P_ready = (ph % 4 == 0) || (ph % 4 == 3);
          ph++;
        end
        default: P_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents something
  initial begin : mon
    logic stall_q;
    logic prev_out;
    logic prev_first;
    stall_q = 1'b0;
    prev_out = 1'b0;
    prev_first = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("we_n", we_n, 1);
        if (!cs_n) begin
          if (q_addr.size() == 0) fail("address", "unexpected read strobe");
          else check("address", address, q_addr.pop_front());
        end
        if (stall_q && P_valid) check("hold", {P_out, P_first}, {prev_out, prev_first});
        if (P_valid && P_ready) begin
          acc_cnt++;
          if (q_bits.size() == 0) fail("bit", "unexpected bit");
          else check("bit", {P_out, P_first}, q_bits.pop_front());
        end
        stall_q = P_valid && !P_ready;
        prev_out = P_out;
        prev_first = P_first;
        if (done) begin
          done_cnt++;
          if (q_err.size() == 0) fail("done", "unexpected done");
          else check("done err", err, q_err.pop_front());
        end
      end else begin
        stall_q = 1'b0;
      end
    end
  end

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy after start", busy, 1);
    check("cs_n after start", cs_n, 0);
  endtask

  task automatic wait_acc(input int n, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (acc_cnt >= n) break;
    end
    if (i == budget) fail("accept wait", "timeout");
  endtask

  task automatic finish_dump(input string name);
    int c0;
    int i;
    c0 = done_cnt;
    for (i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != c0) break;
    end
    if (i == 600) fail({name, " done wait"}, "timeout");
    repeat (4) @(negedge clk);
    #1;
    check({name, " done count"}, done_cnt - c0, 1);
    check({name, " bits left"}, q_bits.size(), 0);
    check({name, " addrs left"}, q_addr.size(), 0);
    check({name, " busy idle"}, busy, 0);
  endtask

  initial begin : main
    int acc0;
    int n;
    int c0;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("in reset", outs(), RstVec);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("idle", outs(), RstVec);
    end

    // Two fixed words, ready tied high
    mem[0] = 32'hA5A5_0F0F;
    mem[1] = 32'h8000_0001;
    fixed_dly = 2;
    rdy_mode = 0;
    acc0 = acc_cnt;
    push_dump(0);
    do_start();
    finish_dump("basic");
    check("basic accepted", acc_cnt - acc0, 64);
    check("basic err", err, 0);

    // Backpressure 1,0,0,1
    rdy_mode = 1;
    acc0 = acc_cnt;
    push_dump(0);
    do_start();
    finish_dump("bp");
    check("bp accepted", acc_cnt - acc0, 64);

    // ry never comes
    rdy_mode = 0;
    sram_mode = 1;
    push_dump(1);
    do_start();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    check("timeout latency", n, TIMEOUT + 1);
    repeat (3) @(negedge clk);
    check("err sticky", err, 1);
    check("busy after timeout", busy, 0);
    check("timeout done popped", q_err.size(), 0);
    sram_mode = 0;
    push_dump(0);
    do_start();
    check("err cleared", err, 0);
    finish_dump("recover");

    // Start ignored mid-shift
    mem[0] = $urandom;
    mem[1] = $urandom;
    rdy_mode = 2;
    acc0 = acc_cnt;
    push_dump(0);
    do_start();
    wait_acc(acc0 + 10, 300);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    finish_dump("restart ignored");

    // Reset in the middle of word 1
    rdy_mode = 0;
    acc0 = acc_cnt;
    push_dump(0);
    do_start();
    wait_acc(acc0 + 40, 300);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async reset", outs(), RstVec);
    q_bits.delete();
    q_addr.delete();
    q_err.delete();
    c0 = done_cnt;
    repeat (12) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("no done on reset", done_cnt - c0, 0);
    push_dump(0);
    do_start();
    check("restart address", address, 0);
    finish_dump("after reset");

    // Random images, delays and backpressure
    fixed_dly = 0;
    rdy_mode = 2;
    for (int k = 0; k < 3; k++) begin
      mem[0] = $urandom;
      mem[1] = $urandom;
      push_dump(0);
      do_start();
      finish_dump("random");
      check("random err", err, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
